// File: rtl/morse_letter_ctrl.sv
// Morse letter controller: latches a letter pattern on a debounced start key and sequences
// the downstream shift counter with a 0.5 s prescaler. Build option: MORSE_RESTART_EN.
module morse_letter_ctrl #(
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic [2:0] letter,
    input  logic       start_n,
    input  logic       rollover,
    output logic [3:0] data,
    output logic [2:0] size,
    output logic       cnt_load_n,
    output logic       E,
    output logic       en_clk,
    output logic       busy
);

    localparam logic [24:0] TickMax = 25'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  data_q, data_d;
    logic [2:0]  size_q, size_d;
    logic [24:0] presc_q, presc_d;
    logic        en_clk_q, en_clk_d;
    logic        e_q, load_n_q, busy_q;

    logic        sync1_q, sync2_q, prev_q;
    logic [1:0]  fill_q;
    logic        armed_q;
    logic        start_evt;

    function automatic logic [6:0] lookup(input logic [2:0] l);
        logic [6:0] r;
        case (l)
            3'd0:    r = {4'b0100, 3'd2};
            3'd1:    r = {4'b1000, 3'd4};
            3'd2:    r = {4'b1010, 3'd4};
            3'd3:    r = {4'b1000, 3'd3};
            3'd4:    r = {4'b0000, 3'd1};
            3'd5:    r = {4'b0010, 3'd4};
            3'd6:    r = {4'b1100, 3'd3};
            default: r = {4'b0000, 3'd4};
        endcase
        return r;
    endfunction

    // Arming waits until the pipeline holds real samples and the key has been seen released,
    // so a key held through reset cannot fake a press.
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= start_n;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            fill_q  <= {fill_q[0], 1'b1};
            if (fill_q[1] && sync2_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign start_evt = armed_q & prev_q & ~sync2_q;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        size_d   = size_q;
        presc_d  = 25'd0;
        en_clk_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_evt) begin
                    {data_d, size_d} = lookup(letter);
                    state_d          = StLoad;
                end
            end
            StLoad: state_d = StRun;
            StRun: begin
                if (rollover) begin
                    state_d = StDone;
                end
`ifdef MORSE_RESTART_EN
                else if (start_evt) begin
                    {data_d, size_d} = lookup(letter);
                    state_d          = StLoad;
                end
`endif
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Prescaler only advances while staying in RUN, so leaving RUN never emits a tick.
        if (state_q == StRun && state_d == StRun) begin
            if (presc_q == TickMax) begin
                en_clk_d = 1'b1;
            end else begin
                presc_d = presc_q + 25'd1;
            end
        end
    end

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            data_q   <= 4'd0;
            size_q   <= 3'd0;
            presc_q  <= 25'd0;
            en_clk_q <= 1'b0;
            e_q      <= 1'b0;
            load_n_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            size_q   <= size_d;
            presc_q  <= presc_d;
            en_clk_q <= en_clk_d;
            e_q      <= (state_d == StRun);
            load_n_q <= (state_d == StRun);
            busy_q   <= (state_d == StRun) || (state_d == StLoad);
        end
    end

    assign data       = data_q;
    assign size       = size_q;
    assign en_clk     = en_clk_q;
    assign E          = e_q;
    assign cnt_load_n = load_n_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_morse_letter_ctrl.sv
// Self-checking bench for morse_letter_ctrl with TICK_DIV=4: letter table vectors plus
// hand-written reset, restart, async-abort and full-letter sequences.
module tb_morse_letter_ctrl;

    logic       Clock, reset, start_n, rollover;
    logic [2:0] letter;
    logic [3:0] data;
    logic [2:0] size;
    logic       cnt_load_n, E, en_clk, busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0] letter;
        logic [3:0] data;
        logic [2:0] size;
    } vec_t;

    vec_t       vecs[8];
    logic [6:0] sb_q[$];

    morse_letter_ctrl #(.TICK_DIV(4)) dut (
        .Clock      (Clock),
        .reset      (reset),
        .letter     (letter),
        .start_n    (start_n),
        .rollover   (rollover),
        .data       (data),
        .size       (size),
        .cnt_load_n (cnt_load_n),
        .E          (E),
        .en_clk     (en_clk),
        .busy       (busy)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Press the key, wait for LOAD, compare the latched pattern, and end in the first RUN cycle.
    task automatic press(input logic [2:0] l, input logic [3:0] ed, input logic [2:0] es);
        logic       got;
        logic [6:0] exp;
        letter  = l;
        start_n = 1'b0;
        sb_q.push_back({ed, es});
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (busy) got = 1'b1;
        end
        check("load_seen", got, 1);
        start_n = 1'b1;
        if (got && sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check("load_data", data, exp[6:3]);
            check("load_size", size, exp[2:0]);
        end
        check("load_E", E, 0);
        check("load_cnt_load_n", cnt_load_n, 0);
        rollover = 1'b1;  // must be ignored outside RUN
        tick();
        rollover = 1'b0;
        check("run_E", E, 1);
        check("run_cnt_load_n", cnt_load_n, 1);
        check("run_busy", busy, 1);
    endtask

    initial begin
        int         cnt, dots, dashes;
        logic       saw_roll, fin;
        logic       exp_e, exp_en;
        logic [3:0] exp_d;
        logic [2:0] exp_s;

        vecs[0] = '{3'd0, 4'b0100, 3'd2};
        vecs[1] = '{3'd1, 4'b1000, 3'd4};
        vecs[2] = '{3'd2, 4'b1010, 3'd4};
        vecs[3] = '{3'd3, 4'b1000, 3'd3};
        vecs[4] = '{3'd4, 4'b0000, 3'd1};
        vecs[5] = '{3'd5, 4'b0010, 3'd4};
        vecs[6] = '{3'd6, 4'b1100, 3'd3};
        vecs[7] = '{3'd7, 4'b0000, 3'd4};

        // Reset with key held low: no start until release and re-press.
        reset = 1'b1; start_n = 1'b0; letter = 3'd0; rollover = 1'b0;
        repeat (3) tick();
        check("rst_data", data, 0);
        check("rst_size", size, 0);
        check("rst_E", E, 0);
        check("rst_en_clk", en_clk, 0);
        check("rst_cnt_load_n", cnt_load_n, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (6) tick();
        check("held_busy", busy, 0);
        check("held_E", E, 0);
        check("held_cnt_load_n", cnt_load_n, 0);
        start_n = 1'b1;
        repeat (4) tick();

        foreach (vecs[v]) begin
            press(vecs[v].letter, vecs[v].data, vecs[v].size);
            for (int k = 0; k <= 8; k++) begin
                check("vec_en_clk", en_clk, (k != 0 && k % 4 == 0));
                check("vec_E", E, 1);
                if (k == 2) letter = vecs[v].letter ^ 3'd5;
                if (k == 5) begin
                    check("vec_data_stable", data, vecs[v].data);
                    check("vec_size_stable", size, vecs[v].size);
                end
                if (k == 8) rollover = 1'b1;
                tick();
            end
            rollover = 1'b0;
            check("done_busy", busy, 0);
            check("done_E", E, 0);
            check("done_cnt_load_n", cnt_load_n, 0);
            check("done_en_clk", en_clk, 0);
            tick();
            check("idle_busy", busy, 0);
            check("idle_data", data, vecs[v].data);
            rollover = 1'b1;
            tick();
            rollover = 1'b0;
            tick();
            check("idle_rollover_ignored", busy, 0);
        end

        // Second press during RUN with letter H.
        press(3'd0, 4'b0100, 3'd2);
        for (int c = 0; c < 16; c++) begin
`ifdef MORSE_RESTART_EN
            exp_e  = (c != 5);
            exp_en = (c == 4 || c == 10 || c == 14);
            exp_d  = (c >= 5) ? 4'b0000 : 4'b0100;
            exp_s  = (c >= 5) ? 3'd4 : 3'd2;
`else
            exp_e  = 1'b1;
            exp_en = (c > 0 && c % 4 == 0);
            exp_d  = 4'b0100;
            exp_s  = 3'd2;
`endif
            check("rs_E", E, exp_e);
            check("rs_cnt_load_n", cnt_load_n, exp_e);
            check("rs_busy", busy, 1);
            check("rs_en_clk", en_clk, exp_en);
            check("rs_data", data, exp_d);
            check("rs_size", size, exp_s);
            if (c == 2) begin
                letter  = 3'd7;
                start_n = 1'b0;
            end
            if (c == 6) start_n = 1'b1;
            tick();
        end
        rollover = 1'b1;
        tick();
        rollover = 1'b0;
        tick();
        check("rs_end_busy", busy, 0);

        // Asynchronous reset mid-RUN, between clock edges, while en_clk is high.
        press(3'd2, 4'b1010, 3'd4);
        repeat (4) tick();
        check("ar_en_clk_pre", en_clk, 1);
        #2 reset = 1'b1;
        #1;
        check("ar_E", E, 0);
        check("ar_en_clk", en_clk, 0);
        check("ar_busy", busy, 0);
        check("ar_data", data, 0);
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("ar_after_busy", busy, 0);

        // Letter H through a downstream shift-counter model.
        press(3'd7, 4'b0000, 3'd4);
        cnt = 0; dots = 0; dashes = 0; saw_roll = 1'b0; fin = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!cnt_load_n) begin
                cnt = 0;
            end else if (E && en_clk && cnt < 4) begin
                if (data[3 - cnt]) dashes++;
                else dots++;
                cnt++;
            end
            rollover = (cnt == 4);
            if (rollover) saw_roll = 1'b1;
            if (!busy) begin
                fin = 1'b1;
                break;
            end
            tick();
        end
        rollover = 1'b0;
        check("h_finished", fin, 1);
        check("h_rollover_seen", saw_roll, 1);
        check("h_dots", dots, 4);
        check("h_dashes", dashes, 0);
        check("h_done_E", E, 0);
        tick();
        check("h_idle_busy", busy, 0);
        check("h_idle_cnt_load_n", cnt_load_n, 0);
        check("sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
